// File: rtl/encoder_4x2_seq.sv
// Sequential 4-to-2 priority encoder: captures a request pattern once it has been
// stable for STABLE_CYCLES clocks and holds the code under a valid/ack handshake.
module encoder_4x2_seq #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] I,
   input  logic       ack,
   output logic       A,
   output logic       B,
   output logic       multi,
   output logic       valid,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, SETTLE, HOLD, RELEASE} state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

   state_t           state, state_n;
   logic [3:0]       snap, snap_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             latch, release_code;
   logic [1:0]       code;
   logic             multi_hot;

   // Code is derived from the live inputs; it is only stored on the latch edge.
   always_comb begin
      if (I[3])      code = 2'd3;
      else if (I[2]) code = 2'd2;
      else if (I[1]) code = 2'd1;
      else           code = 2'd0;
      multi_hot = (I & (I - 4'd1)) != 4'd0;
   end

   always_comb begin
      state_n      = state;
      snap_n       = snap;
      cnt_n        = cnt;
      latch        = 1'b0;
      release_code = 1'b0;
      case (state)
         IDLE: begin
            if (I != 4'd0) begin
               if (STABLE_CYCLES == 1) begin
                  latch   = 1'b1;
                  state_n = HOLD;
               end else begin
                  snap_n  = I;
                  cnt_n   = CNT_W'(1);
                  state_n = SETTLE;
               end
            end
         end
         SETTLE: begin
            if (I == 4'd0) begin
               cnt_n   = '0;
               state_n = IDLE;
            end else if (I != snap) begin
               snap_n = I;
               cnt_n  = CNT_W'(1);
            end else if (cnt == LAST) begin
               latch   = 1'b1;
               cnt_n   = '0;
               state_n = HOLD;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         HOLD: begin
            if (ack) begin
               release_code = 1'b1;
               state_n      = RELEASE;
            end
         end
         RELEASE: begin
            // Wait for the request to drop so a held line is never captured twice.
            if (I == 4'd0) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         snap  <= '0;
         cnt   <= '0;
         A     <= 1'b0;
         B     <= 1'b0;
         multi <= 1'b0;
         valid <= 1'b0;
         busy  <= 1'b0;
      end else begin
         state <= state_n;
         snap  <= snap_n;
         cnt   <= cnt_n;
         busy  <= (state_n != IDLE);
         if (latch) begin
            A     <= code[1];
            B     <= code[0];
            multi <= multi_hot;
            valid <= 1'b1;
         end else if (release_code) begin
            valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_encoder_4x2_seq.sv
// Bench for encoder_4x2_seq: a STABLE_CYCLES=4 and a STABLE_CYCLES=1 instance run
// side by side against a run-length reference model, directed then randomized.
module tb_encoder_4x2_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] I;
   logic       ack;
   logic       a4, b4, m4, v4, bz4;
   logic       a1, b1, m1, v1, bz1;

   int n_pass = 0;
   int n_chk  = 0;

   always #5 clk = ~clk;

   encoder_4x2_seq u_dut4 (
      .clk(clk), .rst(rst), .I(I), .ack(ack),
      .A(a4), .B(b4), .multi(m4), .valid(v4), .busy(bz4)
   );

   encoder_4x2_seq #(.STABLE_CYCLES(1)) u_dut1 (
      .clk(clk), .rst(rst), .I(I), .ack(ack),
      .A(a1), .B(b1), .multi(m1), .valid(v1), .busy(bz1)
   );

   // Reference: length of the current run of identical nonzero samples, plus
   // a "holding a code" flag and a "waiting for the lines to drop" flag.
   int         need   [2] = '{4, 1};
   int         run_len[2];
   logic [3:0] run_pat[2];
   logic       m_hold [2];
   logic       m_wait [2];
   logic [1:0] m_code [2];
   logic       m_multi[2];

   task automatic model_step(input int k);
      int hi;
      if (rst) begin
         run_len[k] = 0; run_pat[k] = 0; m_hold[k] = 0; m_wait[k] = 0;
         m_code[k] = 0; m_multi[k] = 0;
      end else if (m_hold[k]) begin
         if (ack) begin m_hold[k] = 0; m_wait[k] = 1; end
      end else if (m_wait[k]) begin
         if (I == 0) m_wait[k] = 0;
      end else begin
         if (I == 0) run_len[k] = 0;
         else if (run_len[k] > 0 && I == run_pat[k]) run_len[k]++;
         else begin run_pat[k] = I; run_len[k] = 1; end
         if (run_len[k] == need[k]) begin
            hi = 0;
            for (int b = 0; b < 4; b++) if (I[b]) hi = b;
            m_code[k]  = 2'(hi);
            m_multi[k] = $countones(I) >= 2;
            m_hold[k]  = 1;
            run_len[k] = 0;
         end
      end
   endtask

   function automatic logic [4:0] m_out(input int k);
      logic bsy;
      bsy = m_hold[k] || m_wait[k] || run_len[k] > 0;
      return {m_code[k], m_multi[k], m_hold[k], bsy};
   endfunction

   task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s t=%0t got {A,B,multi,valid,busy}=%b exp=%b", tag, $time, got, exp);
   endtask

   task automatic step(input logic r, input logic [3:0] i, input logic k, input string tag);
      rst = r; I = i; ack = k;
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      chk({tag, "/sc4"}, {a4, b4, m4, v4, bz4}, m_out(0));
      chk({tag, "/sc1"}, {a1, b1, m1, v1, bz1}, m_out(1));
   endtask

   task automatic hold(input logic [3:0] i, input int n, input string tag);
      for (int c = 0; c < n; c++) step(1'b0, i, 1'b0, tag);
   endtask

   logic [3:0] pat;
   int         len;

   initial begin
      rst = 1; I = 0; ack = 0;
      // Reset with lines and ack active, then release with I still set.
      step(1'b1, 4'b1000, 1'b1, "reset");
      step(1'b1, 4'b1000, 1'b1, "reset");
      chk("reset_zero", {a4, b4, m4, v4, bz4}, 5'b0);
      step(1'b0, 4'b1000, 1'b0, "rst_rel");
      chk("busy_after_rst", {4'b0, bz4}, 5'b00001);
      hold(4'b1000, 5, "rst_run");
      step(1'b0, 4'b0000, 1'b1, "ack0");
      hold(4'b0000, 2, "idle0");

      // Single-line sweep.
      for (int s = 0; s < 4; s++) begin
         pat = 4'b0001 << s;
         step(1'b0, pat, 1'b0, "sweep_first");
         hold(pat, 2, "sweep_settle");
         step(1'b0, pat, 1'b0, "sweep_cap");
         chk("sweep_code", {a4, b4, m4, v4, 1'b1}, {2'(s), 1'b0, 1'b1, 1'b1});
         hold(pat, 2, "sweep_hold");
         step(1'b0, pat, 1'b1, "sweep_ack");
         hold(4'b0000, 2, "sweep_drop");
      end

      // Priority / multi-hot.
      hold(4'b0110, 4, "prio0110");
      chk("prio0110_code", {a4, b4, m4, v4, 1'b0}, 5'b10110);
      step(1'b0, 4'b0110, 1'b1, "prio_ack");
      hold(4'b0000, 2, "prio_drop");
      hold(4'b1111, 4, "prio1111");
      chk("prio1111_code", {a4, b4, m4, v4, 1'b0}, 5'b11110);
      step(1'b0, 4'b0000, 1'b1, "prio_ack2");
      hold(4'b0000, 2, "prio_drop2");

      // Glitch restart, then abort to IDLE.
      hold(4'b0010, 2, "glitch_a");
      hold(4'b0100, 3, "glitch_b");
      chk("glitch_novalid", {4'b0, v4}, 5'b0);
      step(1'b0, 4'b0100, 1'b0, "glitch_cap");
      chk("glitch_code", {a4, b4, m4, v4, 1'b0}, 5'b10010);
      step(1'b0, 4'b0000, 1'b1, "glitch_ack");
      hold(4'b0000, 2, "glitch_drop");
      step(1'b1, 4'b0000, 1'b0, "rst_mid");
      hold(4'b0010, 2, "abort");
      step(1'b0, 4'b0000, 1'b0, "abort_idle");
      chk("abort_idle", {3'b0, v4, bz4}, 5'b0);

      // Handshake: held request through ack never recaptured; stray ack ignored.
      step(1'b0, 4'b0000, 1'b1, "stray_ack");
      hold(4'b1000, 4, "hs_cap");
      step(1'b0, 4'b1000, 1'b1, "hs_ack");
      chk("hs_valid_fall", {4'b0, v4}, 5'b0);
      hold(4'b1000, 5, "hs_held");
      chk("hs_no_recap", {4'b0, v4}, 5'b0);
      step(1'b0, 4'b0000, 1'b0, "hs_drop");
      hold(4'b0001, 4, "hs_new");
      chk("hs_new_code", {a4, b4, m4, v4, 1'b0}, 5'b00010);
      step(1'b0, 4'b0000, 1'b1, "hs_ack2");
      hold(4'b0000, 2, "hs_drop2");

      // STABLE_CYCLES=1 instance: capture on the first edge; reset clears HOLD.
      step(1'b0, 4'b0100, 1'b0, "sc1_cap");
      chk("sc1_code", {a1, b1, m1, v1, 1'b0}, 5'b10010);
      step(1'b1, 4'b0100, 1'b0, "sc1_rst");
      chk("sc1_rst_clear", {a1, b1, m1, v1, bz1}, 5'b0);

      // Randomized segments.
      for (int seg = 0; seg < 400; seg++) begin
         pat = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
         len = $urandom_range(1, 7);
         for (int c = 0; c < len; c++)
            step(($urandom_range(0, 79) == 0), pat, ($urandom_range(0, 3) == 0), "rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/encoder_4x2_seq.md
Name: encoder_4x2_seq

Overview:
- Sequential 4-to-2 priority encoder; the inverse of the 2x4 decoder.
- Watches four request lines I[3:0] and requires them to hold stable for STABLE_CYCLES consecutive clocks.
- Encodes the highest active line onto A (MSB) and B (LSB), flags multiple active lines, and holds the result under a valid/ack handshake.
- Sits downstream of the decoder or any one-hot source, e.g. for loopback checks or keypad-style capture.

Parameters:
- STABLE_CYCLES, 4: consecutive identical nonzero samples required before capture; legal range 1..255.
- CNT_W, 8: width of the internal stability counter; must hold STABLE_CYCLES.

Ports:
- clk  input  1  single system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- I    input  4  request lines; I[3] has the highest priority.
- ack  input  1  consumer acknowledge; sampled only while valid=1.
- A    output 1  encoded MSB (registered).
- B    output 1  encoded LSB (registered).
- multi output 1  more than one request line was set in the captured pattern (registered).
- valid output 1  A/B/multi hold a captured code (registered).
- busy  output 1  high whenever the FSM is not in IDLE (registered).

Behaviour:
Clock and reset:
- One clock (clk). Reset is synchronous and active-high (rst).
- While rst=1 at an edge: state<=IDLE, snapshot S<=0, cnt<=0, A=B=multi=valid=busy=0.
- rst overrides every other input, including mid-SETTLE and mid-HOLD. A pending code is discarded and never reappears.

FSM states: IDLE, SETTLE, HOLD, RELEASE.

IDLE:
- I==0: stay.
- I!=0 and STABLE_CYCLES==1: latch code, go to HOLD.
- I!=0 otherwise: S<=I, cnt<=1, go to SETTLE.

SETTLE:
- I==0: go to IDLE; nothing is captured.
- I!=S: S<=I, cnt<=1, remain in SETTLE (stability restarts).
- I==S and cnt==STABLE_CYCLES-1: latch code, go to HOLD.
- I==S otherwise: cnt<=cnt+1.

Latch code, registered at the same edge that enters HOLD:
- {A,B} = index of the highest set bit of the sampled I: I[3]->11, I[2]->10, I[1]->01, I[0]->00.
- multi = 1 if popcount(I) >= 2.
- valid <= 1.

HOLD:
- A/B/multi/valid stay frozen; changes on I are ignored.
- ack=1 at an edge: valid<=0, go to RELEASE. A/B/multi keep their last value.

RELEASE:
- Stay until I==0 is sampled, then go to IDLE.
- A request held through ack is never captured twice.

Other rules:
- ack while valid=0 is ignored.
- busy = 1 in SETTLE, HOLD and RELEASE; busy = 0 in IDLE. Registered with the state.
- Latency: a stable nonzero pattern first sampled at edge k gives valid=1 after edge k+STABLE_CYCLES-1. With STABLE_CYCLES=1 that is edge k itself.
- Earliest re-arm after ack: 2 edges. The ack edge enters RELEASE, the next edge with I==0 enters IDLE, and the following edge can sample a new request.
- cnt never exceeds STABLE_CYCLES-1, so it cannot wrap.

Test Plan (STABLE_CYCLES=4 unless noted):
1. Reset:
   - Drive rst=1 for 2 edges with I=4'b1000 and ack=1.
   - Required: A=B=multi=valid=busy=0 after each edge; after release of rst, busy=1 one edge later.
2. Single-line sweep:
   - Apply I=0001, 0010, 0100, 1000 in turn, each held 6 cycles, then ack, then I=0.
   - Required: valid rises exactly 3 edges after the first sample; {A,B}=00, 01, 10, 11 respectively; multi=0.
3. Priority and multi-hot:
   - Hold I=0110 stable.
   - Required: {A,B}=10, multi=1.
   - Repeat with I=1111: {A,B}=11, multi=1.
4. Glitch restart:
   - I=0010 for 2 edges, then 0100 for 4 edges.
   - Required: no valid during the first 0010; valid rises 3 edges after 0100 is first sampled; {A,B}=10.
   - Also: I=0010 for 2 edges then 0000 returns to IDLE, busy=0, nothing captured.
5. Handshake/RELEASE:
   - Hold I=1000 through ack and for 5 more edges.
   - Required: valid falls on the ack edge and does not rise again.
   - Drop I to 0, then apply 0001 for 4 edges: new valid, {A,B}=00.
   - Also: ack pulsed while valid=0 has no effect.
6. STABLE_CYCLES=1 build:
   - Apply I=0100 at one edge.
   - Required: valid=1 and {A,B}=10 after that same edge.
   - Also: rst asserted while in HOLD clears valid on that edge.
